// File: rtl/param_collector_pkg.sv
// Shared types and channel indices for the parameter collector.
// Channel order matches the stale bit order {phase,thd,duty,amp,freq}.
package param_collector_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      PUBLISH = 2'd2
   } state_t;

   localparam int NUM_CH   = 5;
   localparam int CH_FREQ  = 0;
   localparam int CH_AMP   = 1;
   localparam int CH_DUTY  = 2;
   localparam int CH_THD   = 3;
   localparam int CH_PHASE = 4;

endpackage

// File: rtl/param_avg4.sv
// Four-deep moving average with a running sum; only built when
// PARAM_COLLECTOR_AVG_EN is defined.
`ifdef PARAM_COLLECTOR_AVG_EN
module param_avg4 #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  logic         preload_i,
   input  logic [W-1:0] din_i,
   output logic [W-1:0] avg_o
);

   logic [3:0][W-1:0] hist_q;
   logic [W+1:0]      sum_q;

   // Preload fills every slot so the first published average equals the sample.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hist_q <= '0;
         sum_q  <= '0;
      end else if (push_i) begin
         if (preload_i) begin
            hist_q <= {4{din_i}};
            sum_q  <= {din_i, 2'b00};
         end else begin
            hist_q <= {hist_q[2:0], din_i};
            sum_q  <= sum_q - {2'b00, hist_q[3]} + {2'b00, din_i};
         end
      end
   end

   assign avg_o = sum_q[W+1:2];

endmodule
`endif

// File: rtl/param_collector.sv
// Collects five measurement channels into a window and publishes a snapshot.
// Optional freq/amplitude averaging is enabled by defining PARAM_COLLECTOR_AVG_EN.
module param_collector
   import param_collector_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 10_000_000,
   parameter int W              = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         enable,
   input  logic [W-1:0] freq_in,
   input  logic [W-1:0] amp_in,
   input  logic [W-1:0] duty_in,
   input  logic [W-1:0] thd_in,
   input  logic [W-1:0] phase_in,
   input  logic         freq_vld,
   input  logic         amp_vld,
   input  logic         duty_vld,
   input  logic         thd_vld,
   input  logic         phase_vld,
   output logic [W-1:0] freq,
   output logic [W-1:0] amplitude,
   output logic [W-1:0] duty,
   output logic [W-1:0] thd,
   output logic [W-1:0] phase_diff,
   output logic         param_valid,
   output logic [4:0]   stale,
   output logic         timeout_flag
);

   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0]     LAST_CNT = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [NUM_CH-1:0] ALL_GOT  = '1;

   state_t                       state_q;
   logic [NUM_CH-1:0]            gotMask_q, gotMask_d, vldBus;
   logic [CW-1:0]                winCnt_q;
   logic [NUM_CH-1:0][W-1:0]     inBus, shadow_q, shadow_d, pubData_q, pubData_d;
   logic [NUM_CH-1:0]            stale_q;
   logic                         timeout_q, paramValid_q, publishNow;

   assign vldBus = {phase_vld, thd_vld, duty_vld, amp_vld, freq_vld};
   assign inBus  = {phase_in, thd_in, duty_in, amp_in, freq_in};

   // Same-cycle strobes count toward completion and feed the published values.
   always_comb begin
      shadow_d  = shadow_q;
      pubData_d = pubData_q;
      gotMask_d = gotMask_q | vldBus;
      for (int c = 0; c < NUM_CH; c++) begin
         if (vldBus[c]) shadow_d[c] = inBus[c];
      end
      for (int c = 0; c < NUM_CH; c++) begin
         if (gotMask_d[c]) pubData_d[c] = shadow_d[c];
      end
      publishNow = (state_q == COLLECT) && enable &&
                   ((gotMask_d == ALL_GOT) || (winCnt_q == LAST_CNT));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         gotMask_q    <= '0;
         winCnt_q     <= '0;
         shadow_q     <= '0;
         pubData_q    <= '0;
         stale_q      <= '1;
         timeout_q    <= 1'b0;
         paramValid_q <= 1'b0;
      end else begin
         paramValid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               gotMask_q <= '0;
               winCnt_q  <= '0;
               if (enable) state_q <= COLLECT;
            end
            COLLECT: begin
               if (!enable) begin
                  state_q   <= IDLE;
                  gotMask_q <= '0;
                  winCnt_q  <= '0;
               end else begin
                  shadow_q <= shadow_d;
                  if (publishNow) begin
                     state_q      <= PUBLISH;
                     paramValid_q <= 1'b1;
                     pubData_q    <= pubData_d;
                     stale_q      <= ~gotMask_d;
                     timeout_q    <= (gotMask_d != ALL_GOT);
                     gotMask_q    <= '0;
                     winCnt_q     <= '0;
                  end else begin
                     gotMask_q <= gotMask_d;
                     winCnt_q  <= winCnt_q + 1'b1;
                  end
               end
            end
            PUBLISH: begin
               // Strobes arriving here already belong to the next window.
               shadow_q  <= shadow_d;
               winCnt_q  <= '0;
               gotMask_q <= enable ? vldBus : '0;
               state_q   <= enable ? COLLECT : IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign duty         = pubData_q[CH_DUTY];
   assign thd          = pubData_q[CH_THD];
   assign phase_diff   = pubData_q[CH_PHASE];
   assign param_valid  = paramValid_q;
   assign stale        = stale_q;
   assign timeout_flag = timeout_q;

`ifdef PARAM_COLLECTOR_AVG_EN
   logic firstPub_q;

   // History is reseeded by the first publish after leaving IDLE or reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         firstPub_q <= 1'b1;
      end else if (state_q == IDLE) begin
         firstPub_q <= 1'b1;
      end else if (publishNow) begin
         firstPub_q <= 1'b0;
      end
   end

   param_avg4 #(.W(W)) u_avgFreq (
      .clk       (clk),
      .rst       (rst),
      .push_i    (publishNow),
      .preload_i (firstPub_q),
      .din_i     (pubData_d[CH_FREQ]),
      .avg_o     (freq)
   );

   param_avg4 #(.W(W)) u_avgAmp (
      .clk       (clk),
      .rst       (rst),
      .push_i    (publishNow),
      .preload_i (firstPub_q),
      .din_i     (pubData_d[CH_AMP]),
      .avg_o     (amplitude)
   );
`else
   assign freq      = pubData_q[CH_FREQ];
   assign amplitude = pubData_q[CH_AMP];
`endif

endmodule

// File: tb/tb_param_collector.sv
// Randomized and directed bench for param_collector against a behavioural window model.
module tb_param_collector;

   localparam int TO = 100;

   logic        clk, rst, enable;
   logic [15:0] freq_in, amp_in, duty_in, thd_in, phase_in;
   logic        freq_vld, amp_vld, duty_vld, thd_vld, phase_vld;
   logic [15:0] freq, amplitude, duty, thd, phase_diff;
   logic        param_valid, timeout_flag;
   logic [4:0]  stale;

   int vectors = 0;
   int miscompares = 0;

   param_collector #(.TIMEOUT_CYCLES(TO), .W(16)) dut (
      .clk(clk), .rst(rst), .enable(enable),
      .freq_in(freq_in), .amp_in(amp_in), .duty_in(duty_in), .thd_in(thd_in), .phase_in(phase_in),
      .freq_vld(freq_vld), .amp_vld(amp_vld), .duty_vld(duty_vld), .thd_vld(thd_vld), .phase_vld(phase_vld),
      .freq(freq), .amplitude(amplitude), .duty(duty), .thd(thd), .phase_diff(phase_diff),
      .param_valid(param_valid), .stale(stale), .timeout_flag(timeout_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: "collecting" window with age in cycles, and a one-cycle publish slot.
   localparam int M_IDLE = 0, M_COLLECT = 1, M_PUBLISH = 2;
   int       mMode;
   bit [4:0] mGot;
   int       mAge;
   int       mShadow[5];
   int       mOut[5];
   bit [4:0] mStale;
   bit       mTimeout;
   bit       mFirst;
   int       fHist[$];
   int       aHist[$];

   function automatic int meanOf(input int q[$]);
      int s = 0;
      foreach (q[i]) s += q[i];
      return s / 4;
   endfunction

   task automatic modelReset();
      mMode = M_IDLE; mGot = '0; mAge = 0; mStale = 5'h1f; mTimeout = 1'b0; mFirst = 1'b1;
      for (int c = 0; c < 5; c++) begin mShadow[c] = 0; mOut[c] = 0; end
      fHist.delete(); aHist.delete();
   endtask

   task automatic modelCapture();
      int vals[5];
      bit [4:0] v;
      vals = '{int'(freq_in), int'(amp_in), int'(duty_in), int'(thd_in), int'(phase_in)};
      v = {phase_vld, thd_vld, duty_vld, amp_vld, freq_vld};
      for (int c = 0; c < 5; c++) if (v[c]) mShadow[c] = vals[c];
      mGot |= v;
   endtask

   task automatic pushHist(inout int q[$], input int val);
      if (mFirst) q = '{val, val, val, val};
      else begin q.push_back(val); void'(q.pop_front()); end
   endtask

   task automatic modelStep();
      bit [4:0] v;
      v = {phase_vld, thd_vld, duty_vld, amp_vld, freq_vld};
      if (mMode == M_IDLE) begin
         mGot = '0; mAge = 0; mFirst = 1'b1;
         if (enable) mMode = M_COLLECT;
      end else if (mMode == M_PUBLISH) begin
         mGot = '0;
         modelCapture();
         if (!enable) mGot = '0;
         mAge = 0;
         mMode = enable ? M_COLLECT : M_IDLE;
      end else if (!enable) begin
         mMode = M_IDLE; mGot = '0; mAge = 0;
      end else begin
         modelCapture();
         if (mGot == 5'h1f || mAge == TO - 1) begin
            for (int c = 0; c < 5; c++) if (mGot[c]) mOut[c] = mShadow[c];
            mStale = ~mGot;
            mTimeout = (mGot != 5'h1f);
            pushHist(fHist, mOut[0]);
            pushHist(aHist, mOut[1]);
            mFirst = 1'b0; mGot = '0; mAge = 0;
            mMode = M_PUBLISH;
         end else begin
            mAge++;
         end
      end
      if (v == 5'h0) mAge = mAge;
   endtask

   // Compare on the falling edge, then advance the model with this cycle's inputs.
   initial modelReset();
   always @(negedge clk) begin
      int expF, expA;
      if (rst) modelReset();
`ifdef PARAM_COLLECTOR_AVG_EN
      expF = meanOf(fHist);
      expA = meanOf(aHist);
`else
      expF = mOut[0];
      expA = mOut[1];
`endif
      checkOutput("param_valid", int'(param_valid), (mMode == M_PUBLISH) ? 1 : 0);
      checkOutput("stale", int'(stale), int'(mStale));
      checkOutput("timeout_flag", int'(timeout_flag), int'(mTimeout));
      checkOutput("freq", int'(freq), expF);
      checkOutput("amplitude", int'(amplitude), expA);
      checkOutput("duty", int'(duty), mOut[2]);
      checkOutput("thd", int'(thd), mOut[3]);
      checkOutput("phase_diff", int'(phase_diff), mOut[4]);
      if (!rst) modelStep();
   end

   task automatic applyStimulus(input logic en, input logic rv, input logic [4:0] vld,
                                input logic [15:0] f, input logic [15:0] a, input logic [15:0] d,
                                input logic [15:0] t, input logic [15:0] p);
      @(posedge clk);
      #1;
      rst = rv;
      enable = en;
      {phase_vld, thd_vld, duty_vld, amp_vld, freq_vld} = vld;
      freq_in = f; amp_in = a; duty_in = d; thd_in = t; phase_in = p;
   endtask

   task automatic waitValid(output int cyc);
      cyc = -1;
      for (int i = 1; i <= 2 * TO; i++) begin
         applyStimulus(1'b1, 1'b0, 5'b0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
         @(negedge clk);
         if (param_valid) begin cyc = i; break; end
      end
      checkOutput("publish_within_bound", (cyc > 0) ? 1 : 0, 1);
   endtask

   function automatic logic [4:0] randMask(input int den);
      logic [4:0] m;
      for (int b = 0; b < 5; b++) m[b] = ($urandom_range(0, den - 1) == 0);
      return m;
   endfunction

   initial begin
      int cyc;
      int avgExp[4];
      rst = 1'b1; enable = 1'b0;
      {phase_vld, thd_vld, duty_vld, amp_vld, freq_vld} = '0;
      freq_in = '0; amp_in = '0; duty_in = '0; thd_in = '0; phase_in = '0;
      repeat (3) applyStimulus(1'b0, 1'b1, 5'b0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
      @(negedge clk);
      checkOutput("reset_stale", int'(stale), 31);
      checkOutput("reset_freq", int'(freq), 0);
      checkOutput("reset_valid", int'(param_valid), 0);

      // Five strobes on consecutive cycles, one publish pulse the cycle after the last.
      applyStimulus(1'b1, 1'b0, 5'b00000, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
      applyStimulus(1'b1, 1'b0, 5'b00001, 16'd1000, 16'd0, 16'd0, 16'd0, 16'd0);
      applyStimulus(1'b1, 1'b0, 5'b00010, 16'd0, 16'd2000, 16'd0, 16'd0, 16'd0);
      applyStimulus(1'b1, 1'b0, 5'b00100, 16'd0, 16'd0, 16'd500, 16'd0, 16'd0);
      applyStimulus(1'b1, 1'b0, 5'b01000, 16'd0, 16'd0, 16'd0, 16'd30, 16'd0);
      applyStimulus(1'b1, 1'b0, 5'b10000, 16'd0, 16'd0, 16'd0, 16'd0, 16'd1800);
      @(negedge clk);
      checkOutput("complete_no_early_valid", int'(param_valid), 0);
      applyStimulus(1'b1, 1'b0, 5'b0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
      @(negedge clk);
      checkOutput("complete_valid", int'(param_valid), 1);
      checkOutput("complete_freq", int'(freq), 1000);
      checkOutput("complete_stale", int'(stale), 0);
      checkOutput("complete_timeout", int'(timeout_flag), 0);
      applyStimulus(1'b1, 1'b0, 5'b0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
      @(negedge clk);
      checkOutput("valid_single_cycle", int'(param_valid), 0);

      // Latest freq strobe wins.
      applyStimulus(1'b1, 1'b0, 5'b00001, 16'd990, 16'd0, 16'd0, 16'd0, 16'd0);
      applyStimulus(1'b1, 1'b0, 5'b00001, 16'd1010, 16'd0, 16'd0, 16'd0, 16'd0);
      applyStimulus(1'b1, 1'b0, 5'b11110, 16'd0, 16'd2100, 16'd510, 16'd40, 16'd1900);
      applyStimulus(1'b1, 1'b0, 5'b0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
      @(negedge clk);
      checkOutput("overwrite_valid", int'(param_valid), 1);
`ifdef PARAM_COLLECTOR_AVG_EN
      checkOutput("overwrite_freq", int'(freq), 1002);
`else
      checkOutput("overwrite_freq", int'(freq), 1010);
`endif

      // Timeout: only freq/amp strobed in a fresh window.
      applyStimulus(1'b0, 1'b0, 5'b0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
      applyStimulus(1'b0, 1'b0, 5'b0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
      applyStimulus(1'b1, 1'b0, 5'b0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
      applyStimulus(1'b1, 1'b0, 5'b00011, 16'd1234, 16'd77, 16'd0, 16'd0, 16'd0);
      waitValid(cyc);
      checkOutput("timeout_latency", cyc + 1, TO + 1);
      checkOutput("timeout_stale", int'(stale), 28);
      checkOutput("timeout_flag_set", int'(timeout_flag), 1);
      checkOutput("timeout_duty_held", int'(duty), 510);
      checkOutput("timeout_phase_held", int'(phase_diff), 1900);

      // Drop enable after three strobes; the partial window must vanish.
      applyStimulus(1'b1, 1'b0, 5'b00001, 16'd4000, 16'd0, 16'd0, 16'd0, 16'd0);
      applyStimulus(1'b1, 1'b0, 5'b00010, 16'd0, 16'd4001, 16'd0, 16'd0, 16'd0);
      applyStimulus(1'b1, 1'b0, 5'b00100, 16'd0, 16'd0, 16'd777, 16'd0, 16'd0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b0, 5'b0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
         @(negedge clk);
         checkOutput("disable_no_valid", int'(param_valid), 0);
      end
      checkOutput("disable_duty_held", int'(duty), 510);
      applyStimulus(1'b1, 1'b0, 5'b0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
      applyStimulus(1'b1, 1'b0, 5'b11011, 16'd3000, 16'd300, 16'd0, 16'd60, 16'd100);
      waitValid(cyc);
      checkOutput("reenable_stale", int'(stale), 4);
      checkOutput("reenable_duty_discarded", int'(duty), 510);
      checkOutput("reenable_thd", int'(thd), 60);

      // Asynchronous reset in the middle of a window.
      applyStimulus(1'b1, 1'b0, 5'b00101, 16'd55, 16'd0, 16'd66, 16'd0, 16'd0);
      applyStimulus(1'b1, 1'b1, 5'b0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
      @(negedge clk);
      checkOutput("midreset_thd", int'(thd), 0);
      checkOutput("midreset_stale", int'(stale), 31);
      checkOutput("midreset_valid", int'(param_valid), 0);

`ifdef PARAM_COLLECTOR_AVG_EN
      avgExp = '{1000, 1001, 1003, 1006};
      applyStimulus(1'b0, 1'b0, 5'b0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 1'b0, 5'b0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
         applyStimulus(1'b1, 1'b0, 5'b11111, 16'(1000 + 4 * i), 16'd9, 16'd9, 16'd9, 16'd9);
         applyStimulus(1'b1, 1'b0, 5'b0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
         @(negedge clk);
         checkOutput("avg_freq", int'(freq), avgExp[i]);
      end
`else
      avgExp = '{0, 0, 0, 0};
`endif

      // Random traffic: dense strobes, then sparse strobes that force timeouts.
      for (int i = 0; i < 2000; i++)
         applyStimulus(($urandom_range(0, 39) != 0), ($urandom_range(0, 599) == 0), randMask(6),
                       16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                       16'($urandom_range(0, 1000)), 16'($urandom_range(0, 1000)),
                       16'($urandom_range(0, 3599)));
      for (int i = 0; i < 1500; i++)
         applyStimulus(($urandom_range(0, 299) != 0), ($urandom_range(0, 999) == 0), randMask(150),
                       16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                       16'($urandom_range(0, 1000)), 16'($urandom_range(0, 1000)),
                       16'($urandom_range(0, 3599)));

      applyStimulus(1'b0, 1'b0, 5'b0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
      @(negedge clk);
      @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
